// File: rtl/sar_adc_scan_ctrl_if.sv
// Bus between the SAR scan controller and its sequencer / analog front end.
// Optional window-compare signals are present when SAR_ADC_WINDOW_EN is defined.
interface sar_adc_scan_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic              start_conversion;
  logic [NUM_CH-1:0] ch_mask;
  logic              abort;
  logic              comparator_in;
  logic [CH_W-1:0]   mux_sel;
  logic [WIDTH-1:0]  dac_value;
  logic [WIDTH-1:0]  result;
  logic [CH_W-1:0]   result_ch;
  logic              valid;
  logic              busy;
`ifdef SAR_ADC_WINDOW_EN
  logic [WIDTH-1:0]  win_lo;
  logic [WIDTH-1:0]  win_hi;
  logic              out_of_window;

  modport slave (
    input  start_conversion, ch_mask, abort, comparator_in, win_lo, win_hi,
    output mux_sel, dac_value, result, result_ch, valid, busy, out_of_window
  );
  modport master (
    output start_conversion, ch_mask, abort, comparator_in, win_lo, win_hi,
    input  mux_sel, dac_value, result, result_ch, valid, busy, out_of_window
  );
`else
  modport slave (
    input  start_conversion, ch_mask, abort, comparator_in,
    output mux_sel, dac_value, result, result_ch, valid, busy
  );
  modport master (
    output start_conversion, ch_mask, abort, comparator_in,
    input  mux_sel, dac_value, result, result_ch, valid, busy
  );
`endif
endinterface

// File: rtl/sar_adc_scan_ctrl.sv
// Multi-channel SAR ADC scan controller: masked channel scan, one binary search per channel.
// Optional window comparator enabled by defining SAR_ADC_WINDOW_EN.
module sar_adc_scan_ctrl #(
  parameter int WIDTH             = 8,
  parameter int NUM_CH            = 4,
  parameter int CH_W              = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int SETTLE_CYCLES     = 1,
  parameter int MUX_SETTLE_CYCLES = 2
) (
  input logic                clk,
  input logic                rst_n,
  sar_adc_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_MUX_SETTLE = 2'd1,
    ST_TRIAL      = 2'd2,
    ST_DONE       = 2'd3
  } state_e;

  localparam int BIT_W   = $clog2(WIDTH);
  localparam int CNT_MAX = (SETTLE_CYCLES > MUX_SETTLE_CYCLES) ? SETTLE_CYCLES : MUX_SETTLE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 32'sd1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 32'sd1);
  localparam logic [CNT_W-1:0] MUX_LAST    =
    CNT_W'((MUX_SETTLE_CYCLES > 32'sd0) ? (MUX_SETTLE_CYCLES - 32'sd1) : 32'sd0);
  localparam logic [BIT_W-1:0] MSB_IDX     = BIT_W'(WIDTH - 32'sd1);
  localparam logic [WIDTH-1:0] ONE_CODE    = WIDTH'(1'b1);
  localparam logic [WIDTH-1:0] MSB_CODE    = ONE_CODE << MSB_IDX;
  // With no mux settling the channel select is followed directly by the MSB trial.
  localparam state_e SETTLE_ENTRY = (MUX_SETTLE_CYCLES == 32'sd0) ? ST_TRIAL : ST_MUX_SETTLE;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [WIDTH-1:0]  code_q, code_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [CH_W-1:0]   mux_sel_q, mux_sel_d;
  logic [WIDTH-1:0]  dac_q, dac_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [CH_W-1:0]   result_ch_q, result_ch_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
`ifdef SAR_ADC_WINDOW_EN
  logic              oow_q, oow_d;
`endif

  logic              start_ok_s;
  logic              settle_done_s;
  logic [WIDTH-1:0]  trial_s;
  logic [WIDTH-1:0]  decided_s;

  function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
    lowest_set = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (m[k]) lowest_set = CH_W'(k);
    end
  endfunction

  assign start_ok_s    = bus.start_conversion && (bus.ch_mask != '0);
  assign settle_done_s = (cnt_q == SETTLE_LAST);
  assign trial_s       = code_q | (ONE_CODE << bit_q);
  assign decided_s     = bus.comparator_in ? trial_s : code_q;

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      code_q      <= '0;
      mask_q      <= '0;
      mux_sel_q   <= '0;
      dac_q       <= '0;
      result_q    <= '0;
      result_ch_q <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SAR_ADC_WINDOW_EN
      oow_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      code_q      <= code_d;
      mask_q      <= mask_d;
      mux_sel_q   <= mux_sel_d;
      dac_q       <= dac_d;
      result_q    <= result_d;
      result_ch_q <= result_ch_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
`ifdef SAR_ADC_WINDOW_EN
      oow_q       <= oow_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok_s) state_d = SETTLE_ENTRY;
        else            state_d = ST_IDLE;
      end
      ST_MUX_SETTLE: begin
        if (bus.abort)               state_d = ST_IDLE;
        else if (cnt_q == MUX_LAST)  state_d = ST_TRIAL;
        else                         state_d = ST_MUX_SETTLE;
      end
      ST_TRIAL: begin
        if (bus.abort)                            state_d = ST_IDLE;
        else if (settle_done_s && (bit_q == '0))  state_d = ST_DONE;
        else                                      state_d = ST_TRIAL;
      end
      ST_DONE: begin
        // The channel bit was cleared on entry, so mask_q holds only pending channels.
        if (bus.abort || (mask_q == '0)) state_d = ST_IDLE;
        else                             state_d = SETTLE_ENTRY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    code_d      = code_q;
    mask_d      = mask_q;
    mux_sel_d   = mux_sel_q;
    dac_d       = dac_q;
    result_d    = result_q;
    result_ch_d = result_ch_q;
    valid_d     = 1'b0;
    busy_d      = (state_d != ST_IDLE);
`ifdef SAR_ADC_WINDOW_EN
    oow_d       = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_ok_s) begin
          mask_d    = bus.ch_mask;
          mux_sel_d = lowest_set(bus.ch_mask);
        end else begin
          mask_d    = mask_q;
        end
      end
      ST_MUX_SETTLE: begin
        if (bus.abort) begin
          mask_d = '0;
          dac_d  = '0;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1'b1);
        end
      end
      ST_TRIAL: begin
        if (bus.abort) begin
          mask_d = '0;
          dac_d  = '0;
        end else if (settle_done_s) begin
          if (bit_q == '0) begin
            result_d    = decided_s;
            dac_d       = decided_s;
            result_ch_d = mux_sel_q;
            valid_d     = 1'b1;
            mask_d      = mask_q & ~(NUM_CH'(1'b1) << mux_sel_q);
`ifdef SAR_ADC_WINDOW_EN
            oow_d       = (decided_s < bus.win_lo) || (decided_s > bus.win_hi);
`endif
          end else begin
            bit_d  = bit_q - BIT_W'(1'b1);
            code_d = decided_s;
            dac_d  = decided_s | (ONE_CODE << (bit_q - BIT_W'(1'b1)));
            cnt_d  = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1'b1);
        end
      end
      ST_DONE: begin
        if (bus.abort) begin
          mask_d = '0;
          dac_d  = '0;
        end else if (mask_q != '0) begin
          mux_sel_d = lowest_set(mask_q);
        end else begin
          mask_d = '0;
        end
      end
      default: begin
        mask_d = '0;
        dac_d  = '0;
      end
    endcase
    // Entry actions shared by every path into a settling or trial phase.
    if ((state_d == ST_MUX_SETTLE) && (state_q != ST_MUX_SETTLE)) begin
      cnt_d = '0;
      dac_d = '0;
    end else if ((state_d == ST_TRIAL) && (state_q != ST_TRIAL)) begin
      cnt_d  = '0;
      bit_d  = MSB_IDX;
      code_d = '0;
      dac_d  = MSB_CODE;
    end else begin
      cnt_d = cnt_d;
    end
  end

  assign bus.mux_sel   = mux_sel_q;
  assign bus.dac_value = dac_q;
  assign bus.result    = result_q;
  assign bus.result_ch = result_ch_q;
  assign bus.valid     = valid_q;
  assign bus.busy      = busy_q;
`ifdef SAR_ADC_WINDOW_EN
  assign bus.out_of_window = oow_q;
`endif

endmodule

// File: doc/sar_adc_scan_ctrl.md
Name: sar_adc_scan_ctrl

Overview:
Parametrised successive-approximation ADC controller, successor to the single-channel 8-bit SAR controller.
- Scans a masked set of analog channels through an external analog mux.
- Runs one WIDTH-bit binary search per channel, with programmable DAC and mux settling.
- Supports synchronous abort.
- Sits between the sequencer/CPU (start, mask, results) and the analog front end (mux select, DAC code, comparator).

Parameters:
WIDTH, 8, DAC/result resolution in bits (2..16)
NUM_CH, 4, number of analog channels (1..16)
CH_W, $clog2(NUM_CH) min 1, channel index width (derived)
SETTLE_CYCLES, 1, clocks each trial code is held before the comparator is sampled (>=1)
MUX_SETTLE_CYCLES, 2, clocks after a mux_sel change before the MSB trial (>=0)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start_conversion  in  1  one-cycle request to begin a scan
ch_mask  in  NUM_CH  channels to convert; sampled only on an accepted start
abort  in  1  synchronous abort of the scan in progress
comparator_in  in  1  1 when Vin >= Vdac(dac_value); externally synchronised
mux_sel  out  CH_W  analog mux channel select
dac_value  out  WIDTH  DAC code (trial code, then final code)
result  out  WIDTH  converted code, held until the next valid
result_ch  out  CH_W  channel index of result
valid  out  1  one-cycle pulse: result/result_ch updated this cycle
busy  out  1  scan in progress

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; mux_sel, dac_value, result, result_ch = 0; valid, busy = 0; latched mask cleared. Reset takes priority over every other input, including mid-scan.
- States: IDLE, MUX_SETTLE, TRIAL, DONE. busy = (state != IDLE), registered.
- IDLE:
  - start_conversion=1 with ch_mask!=0: latch mask, set mux_sel to the lowest set bit, go to MUX_SETTLE. busy is high in the next cycle.
  - start with ch_mask=0: ignored.
  - start while busy: ignored, no queueing.
- MUX_SETTLE: hold for MUX_SETTLE_CYCLES clocks. If the value is 0, go directly to TRIAL. dac_value = 0 in this state.
- TRIAL: bit index i runs MSB..LSB.
  - Trial code = (decided bits) | (1<<i); lower bits are 0.
  - The trial code is driven on dac_value for exactly SETTLE_CYCLES clocks.
  - comparator_in is sampled at the edge ending the last of those clocks: 1 keeps bit i, 0 clears it.
  - After the LSB decision, go to DONE.
- DONE (1 cycle):
  - dac_value = final code; result = final code; result_ch = mux_sel; valid = 1.
  - Clear the channel's bit in the latched mask.
  - If bits remain: mux_sel = next higher set bit, go to MUX_SETTLE.
  - Otherwise go to IDLE; busy drops the following cycle.
- Per-channel latency, start/channel-select to valid: MUX_SETTLE_CYCLES + WIDTH*SETTLE_CYCLES + 1 clocks. Defaults give 11.
- Channels are converted in ascending index order. Unmasked channels are skipped with zero cycle cost.
- valid and busy are both high during every DONE cycle. This is legal.
- abort=1 in any non-IDLE state: next state IDLE, no valid for the partial channel, result/result_ch unchanged, dac_value = 0, mask cleared. abort in IDLE has no effect. If abort and a DONE cycle coincide, that DONE still completes (valid pulses) and the scan then ends.
- Arithmetic is unsigned, with no wrap. A full-scale input converts to all-ones, a zero input to 0.

Optional Feature:
Macro SAR_ADC_WINDOW_EN.
- Defined:
  - Adds input ports win_lo [WIDTH] and win_hi [WIDTH].
  - Adds output port out_of_window [1], registered, reset 0.
  - out_of_window is high only in a valid cycle whose result < win_lo or result > win_hi. The thresholds are inclusive bounds of the in-window range.
  - If win_lo > win_hi, every result flags.
- Undefined: these ports and the logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset then single channel: mask=4'b0001, comparator model Vin=8'd0 → after 11 clocks valid=1, result=0, result_ch=0; busy low the cycle after.
- Full scale and midscale: mask=4'b0001, Vin=255 then Vin=128 → result 255 then 128. Trial sequence observed on dac_value is 128,192,160,... for Vin=173, final 173.
- Scan with gaps: mask=4'b1010, Vin ch1=37, ch3=99 → valid twice, 11 clocks apart, (result_ch,result) = (1,37) then (3,99); mux_sel goes 1→3.
- Start ignored: start with mask=0 → busy stays 0. Start while busy → no extra conversion, no mask change.
- Abort: assert abort 5 clocks into ch0 (Vin=200) → IDLE next cycle, no valid, result keeps its previous value. A new start then converts 200 correctly.
- Window (SAR_ADC_WINDOW_EN, win_lo=50, win_hi=150): Vin=49, 50, 150, 151 → out_of_window = 1, 0, 0, 1 on the respective valid pulses. Reset mid-scan (rst_n=0 one clock) → all outputs 0 next cycle.
